// File: rtl/mesh_pkg.sv
// Shared port indices, flit layout and XY routing helper for the mesh router.
package mesh_pkg;

    localparam int unsigned NUM_PORTS   = 5;
    localparam int unsigned PORT_W      = 3;
    localparam int unsigned DEF_COORD_W = 16;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned PAYLOAD_LSB = 0;
    localparam int unsigned ROUTE_ARG_W = 32;

    typedef enum logic [PORT_W-1:0] {
        P_LOCAL = 3'd0,
        P_LEFT  = 3'd1,
        P_RIGHT = 3'd2,
        P_UP    = 3'd3,
        P_DOWN  = 3'd4
    } port_e;

    typedef struct packed {
        logic  illegal;
        port_e port;
    } route_t;

    // X first, then Y; Y grows downward, X grows rightward, coordinates are 1-based.
    function automatic route_t xy_route(
        input logic [ROUTE_ARG_W-1:0] dst_x,
        input logic [ROUTE_ARG_W-1:0] dst_y,
        input logic [ROUTE_ARG_W-1:0] my_x,
        input logic [ROUTE_ARG_W-1:0] my_y,
        input logic [ROUTE_ARG_W-1:0] mesh_x,
        input logic [ROUTE_ARG_W-1:0] mesh_y
    );
        route_t r;
        r.illegal = (dst_x == '0) || (dst_x > mesh_x) || (dst_y == '0) || (dst_y > mesh_y);
        if (dst_x > my_x)      r.port = P_RIGHT;
        else if (dst_x < my_x) r.port = P_LEFT;
        else if (dst_y > my_y) r.port = P_DOWN;
        else if (dst_y < my_y) r.port = P_UP;
        else                   r.port = P_LOCAL;
        return r;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous first-word-fallthrough FIFO; dout presents the head whenever !empty.
module router_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mesh_router.sv
// 5-port XY mesh router: per-input FWFT FIFOs, per-output round-robin arbiter and output register.
module mesh_router
    import mesh_pkg::*;
#(
    parameter  int unsigned COORD_W    = DEF_COORD_W,
    parameter  int unsigned DATA_W     = DEF_DATA_W,
    parameter  int unsigned MESH_X     = 3,
    parameter  int unsigned MESH_Y     = 3,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned FLIT_W     = 2*COORD_W + DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COORD_W-1:0]            my_x,
    input  logic [COORD_W-1:0]            my_y,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*FLIT_W-1:0]   in_flit,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic [NUM_PORTS*FLIT_W-1:0]   out_flit,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [15:0]                   drop_count
);

    localparam int unsigned DSTY_LSB = PAYLOAD_LSB + DATA_W;
    localparam int unsigned DSTX_LSB = DSTY_LSB + COORD_W;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] head_ok;
    logic [NUM_PORTS-1:0] drop;
    logic [FLIT_W-1:0]    head_flit [NUM_PORTS];
    port_e                head_port [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_all   [NUM_PORTS];
    logic [16:0]          drop_sum;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        logic [CNT_W-1:0] count;
        route_t           route;

        router_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[p]),
            .din   (in_flit[p*FLIT_W +: FLIT_W]),
            .pop   (pop[p]),
            .dout  (head_flit[p]),
            .full  (full[p]),
            .empty (empty[p]),
            .count (count)
        );

        // Ready comes from registered occupancy only, so a full FIFO refuses even while popping.
        assign in_ready[p] = ~rst & (count != CNT_W'(FIFO_DEPTH));
        assign push[p]     = in_valid[p] & ~full[p] & ~rst;

        assign route = xy_route(ROUTE_ARG_W'(head_flit[p][DSTX_LSB +: COORD_W]),
                                ROUTE_ARG_W'(head_flit[p][DSTY_LSB +: COORD_W]),
                                ROUTE_ARG_W'(my_x), ROUTE_ARG_W'(my_y),
                                ROUTE_ARG_W'(MESH_X), ROUTE_ARG_W'(MESH_Y));
        assign head_ok[p]   = ~empty[p] & ~route.illegal;
        assign drop[p]      = ~empty[p] & route.illegal;
        assign head_port[p] = route.port;
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [NUM_PORTS-1:0] req;
        logic [NUM_PORTS-1:0] gnt;
        logic [PORT_W-1:0]    ptr;
        logic [PORT_W-1:0]    winner;
        logic [PORT_W-1:0]    idx;
        logic                 load;
        logic                 valid_q;
        logic [FLIT_W-1:0]    flit_q;

        assign load = ~valid_q | out_ready[o];

        // Search starts at ptr, which always holds the port after the previous winner.
        always_comb begin
            req    = '0;
            gnt    = '0;
            winner = '0;
            idx    = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                req[p] = head_ok[p] && (head_port[p] == port_e'(o));
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                idx = PORT_W'((32'(ptr) + i) % NUM_PORTS);
                if (load && (gnt == '0) && req[idx]) begin
                    gnt[idx] = 1'b1;
                    winner   = idx;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                flit_q  <= '0;
                ptr     <= '0;
            end else if (gnt != '0) begin
                valid_q <= 1'b1;
                flit_q  <= head_flit[winner];
                ptr     <= (winner == PORT_W'(NUM_PORTS-1)) ? '0 : winner + PORT_W'(1);
            end else if (out_ready[o]) begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid[o]                  = valid_q;
        assign out_flit[o*FLIT_W +: FLIT_W]  = flit_q;
        assign gnt_all[o]                    = gnt;
    end

    always_comb begin
        pop = drop;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            pop |= gnt_all[o];
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_count};
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            drop_sum += 17'(drop[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) drop_count <= '0;
        else     drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

endmodule

// File: tb/tb_mesh_router.sv
// Bench for mesh_router at (2,2) in a 3x3 mesh: vector table, corner sequences, random scoreboard.
module tb_mesh_router;

    localparam int unsigned NP = 5;
    localparam int unsigned FW = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [15:0]     my_x = 16'd2;
    logic [15:0]     my_y = 16'd2;
    logic [NP-1:0]   in_valid = '0;
    logic [NP-1:0]   in_ready;
    logic [NP*FW-1:0] in_flit = '0;
    logic [NP-1:0]   out_valid;
    logic [NP*FW-1:0] out_flit;
    logic [NP-1:0]   out_ready = '1;
    logic [15:0]     drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          src;
        int          x;
        int          y;
        logic [31:0] pl;
        int          exp;
    } vec_t;

    typedef struct {
        int          port;
        logic [63:0] flit;
    } sb_t;

    vec_t        vt [14];
    sb_t         sb [$];
    int          rdrops;
    logic [NP-1:0] stall = '0;
    logic [63:0] held [NP];

    mesh_router #(
        .COORD_W    (16),
        .DATA_W     (32),
        .MESH_X     (3),
        .MESH_Y     (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .my_x       (my_x),
        .my_y       (my_y),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_flit   (out_flit),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] mk(input int x, input int y, input logic [31:0] pl);
        return {16'(x), 16'(y), pl};
    endfunction

    function automatic logic [63:0] oflit(input int o);
        return out_flit[o*FW +: FW];
    endfunction

    // Destination port from the mesh rules for a router at (2,2) in a 3x3 grid; -1 means dropped.
    function automatic int ref_port(input int x, input int y);
        if (x < 1 || x > 3 || y < 1 || y > 3) return -1;
        if (x > 2) return 2;
        if (x < 2) return 1;
        if (y > 2) return 4;
        if (y < 2) return 3;
        return 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic [63:0] f);
        in_valid[p]          = 1'b1;
        in_flit[p*FW +: FW]  = f;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        @(negedge clk);
        check("in_ready_during_rst", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic bp_fill(output int k);
        k = 0;
        out_ready = 5'b11011;
        repeat (12) begin
            @(posedge clk); #1;
            in_valid[1]      = (k < 6);
            in_flit[FW +: FW] = mk(3, 2, 32'hB000_0000 + 32'(k));
            @(negedge clk);
            if (in_valid[1] && in_ready[1]) k++;
        end
    endtask

    task automatic sample();
        logic [63:0] f;
        int          d;
        int          idx;
        for (int p = 0; p < NP; p++) begin
            if (in_valid[p] && in_ready[p]) begin
                f = in_flit[p*FW +: FW];
                d = ref_port(int'(f[63:48]), int'(f[47:32]));
                if (d < 0) rdrops++;
                else       sb.push_back('{d, f});
            end
        end
        for (int o = 0; o < NP; o++) begin
            f = oflit(o);
            if (stall[o]) begin
                check("hold_valid", 64'(out_valid[o]), 64'h1);
                check("hold_flit", f, held[o]);
            end
            if (out_valid[o] && out_ready[o]) begin
                idx = -1;
                foreach (sb[i]) begin
                    if (idx < 0 && sb[i].port == o && sb[i].flit[31:24] == f[31:24]) idx = i;
                end
                if (idx < 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h on port %0d, required no flit", f, o);
                end else begin
                    check("sb_flit", f, sb[idx].flit);
                    sb.delete(idx);
                end
            end
            stall[o] = out_valid[o] && !out_ready[o];
            held[o]  = f;
        end
    endtask

    initial begin
        int          drops;
        int          k;
        int          n;
        int          x;
        int          y;
        int          seq;
        logic [63:0] got [6];
        int          ord1 [3];
        int          ord2 [4];

        vt[0]  = '{0, 3, 2, 32'hDEADBEEF, 2};
        vt[1]  = '{1, 2, 2, 32'h0000_0005, 0};
        vt[2]  = '{3, 2, 1, 32'h0000_A003, 3};
        vt[3]  = '{2, 1, 2, 32'h0000_B004, 1};
        vt[4]  = '{4, 2, 3, 32'h0000_C005, 4};
        vt[5]  = '{0, 3, 1, 32'h0000_D006, 2};
        vt[6]  = '{0, 1, 3, 32'h0000_E007, 1};
        vt[7]  = '{2, 2, 2, 32'h0000_F008, 0};
        vt[8]  = '{0, 0, 1, 32'h0000_0009, -1};
        vt[9]  = '{1, 4, 2, 32'h0000_000A, -1};
        vt[10] = '{3, 2, 0, 32'h0000_000B, -1};
        vt[11] = '{4, 2, 4, 32'h0000_000C, -1};
        vt[12] = '{4, 3, 3, 32'h0000_000D, 2};
        vt[13] = '{1, 1, 2, 32'h0000_000E, 1};
        ord1 = '{0, 1, 3};
        ord2 = '{4, 0, 1, 3};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        for (int o = 0; o < NP; o++) check($sformatf("rst_out_flit%0d", o), oflit(o), 64'h0);
        check("rst_drop_count", 64'(drop_count), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'h1F);

        // Single-flit vectors: routing, one-cycle latency, drops
        drops = 0;
        foreach (vt[i]) begin
            @(posedge clk); #1;
            drive(vt[i].src, mk(vt[i].x, vt[i].y, vt[i].pl));
            @(posedge clk); #1;
            in_valid = '0;
            @(negedge clk);
            check($sformatf("vec%0d_lat0", i), 64'(out_valid), 64'h0);
            @(negedge clk);
            if (vt[i].exp < 0) drops++;
            check($sformatf("vec%0d_valid", i), 64'(out_valid),
                  (vt[i].exp < 0) ? 64'h0 : 64'(1 << vt[i].exp));
            if (vt[i].exp >= 0)
                check($sformatf("vec%0d_flit", i), oflit(vt[i].exp), mk(vt[i].x, vt[i].y, vt[i].pl));
            check($sformatf("vec%0d_drops", i), 64'(drop_count), 64'(drops));
            check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'h1F);
        end

        // Contention on the right output, then a second burst after the pointer has moved
        do_reset();
        foreach (ord1[j]) drive(ord1[j], mk(3, 2, {8'(ord1[j]), 24'hC0_0001}));
        @(posedge clk); #1;
        in_valid = '0;
        foreach (ord1[j]) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("cont1_valid%0d", j), 64'(out_valid), 64'h4);
            check($sformatf("cont1_flit%0d", j), oflit(2), mk(3, 2, {8'(ord1[j]), 24'hC0_0001}));
        end
        @(posedge clk); #1;
        foreach (ord2[j]) drive(ord2[j], mk(3, 2, {8'(ord2[j]), 24'hC0_0002}));
        @(posedge clk); #1;
        in_valid = '0;
        foreach (ord2[j]) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("cont2_flit%0d", j), oflit(2), mk(3, 2, {8'(ord2[j]), 24'hC0_0002}));
        end

        // Backpressure: 4 in FIFO + 1 in output register, then in-order release
        do_reset();
        bp_fill(k);
        check("bp_accepted", 64'(k), 64'd5);
        check("bp_in_ready", 64'(in_ready[1]), 64'h0);
        check("bp_out_valid", 64'(out_valid), 64'h4);
        check("bp_head_flit", oflit(2), mk(3, 2, 32'hB000_0000));
        n = 0;
        for (int c = 0; c < 20 && n < 6; c++) begin
            @(posedge clk); #1;
            out_ready         = '1;
            in_valid[1]       = (k < 6);
            in_flit[FW +: FW] = mk(3, 2, 32'hB000_0000 + 32'(k));
            @(negedge clk);
            if (in_valid[1] && in_ready[1]) k++;
            if (out_valid[2] && out_ready[2]) begin
                got[n] = oflit(2);
                n++;
            end
        end
        in_valid = '0;
        check("bp_delivered", 64'(n), 64'd6);
        for (int i = 0; i < n; i++) check($sformatf("bp_order%0d", i), got[i], mk(3, 2, 32'hB000_0000 + 32'(i)));

        // Reset while backpressured
        do_reset();
        drive(0, mk(0, 1, 32'h0000_0BAD));
        @(posedge clk); #1;
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("mid_drop_before", 64'(drop_count), 64'd1);
        bp_fill(k);
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = '0;
        @(negedge clk);
        check("mid_in_ready_rst", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = '1;
        @(negedge clk);
        check("mid_out_valid", 64'(out_valid), 64'h0);
        check("mid_drop_count", 64'(drop_count), 64'h0);
        check("mid_in_ready", 64'(in_ready), 64'h1F);
        @(posedge clk); #1;
        drive(0, mk(2, 3, 32'h000F_1E55));
        @(posedge clk); #1;
        in_valid = '0;
        @(negedge clk);
        check("mid_no_stale", 64'(out_valid), 64'h0);
        @(negedge clk);
        check("mid_fresh_valid", 64'(out_valid), 64'h10);
        check("mid_fresh_flit", oflit(4), mk(2, 3, 32'h000F_1E55));

        // Random traffic against the scoreboard
        do_reset();
        sb.delete();
        rdrops = 0;
        seq    = 0;
        stall  = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < NP; p++) begin
                in_valid[p] = ($urandom_range(0, 99) < 60);
                x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 3));
                y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 3));
                in_flit[p*FW +: FW] = mk(x, y, {8'(p), 24'(seq)});
                seq++;
            end
            for (int o = 0; o < NP; o++) out_ready[o] = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            sample();
        end
        @(posedge clk); #1;
        in_valid  = '0;
        out_ready = '1;
        repeat (40) begin
            @(negedge clk);
            sample();
        end
        check("rand_all_delivered", 64'(sb.size()), 64'd0);
        check("rand_drop_count", 64'(drop_count), 64'(rdrops));

        // Five drops per cycle, then saturation
        do_reset();
        for (int p = 0; p < NP; p++) drive(p, mk(0, 0, 32'(p)));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("sat_first_cycle", 64'(drop_count), 64'd5);
        repeat (13100) @(negedge clk);
        check("sat_below", 64'(drop_count), 64'd65505);
        repeat (20) @(negedge clk);
        check("sat_clamped", 64'(drop_count), 64'hFFFF);
        check("sat_no_output", 64'(out_valid), 64'h0);
        check("sat_in_ready", 64'(in_ready), 64'h1F);
        @(posedge clk); #1;
        in_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
